// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-4 Booth,
// one recoded digit per clock, start/busy/done handshake.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as every remaining
// Booth digit is zero (data-dependent latency, identical product).
//
// Handshake: start is sampled on a rising clock edge and accepted only when
// the block is not busy (IDLE or DONE); busy is high exactly while digits are
// being processed; done is a one-cycle pulse during which Mulout carries the
// product; Mulout then holds until the next accepted multiply completes.
module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Mulout,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH / 2) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    state_t             state;
    state_t             state_next;

    // Multiplicand is kept two bits wider so +/-2A never overflows.
    logic [WIDTH+1:0]   mcand;
    // hi accumulates partial products; lo starts as B and fills with product bits.
    logic [WIDTH+1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               q_m1;
    logic [CW-1:0]      cnt;

    logic [2:0]         window;
    logic [WIDTH+1:0]   pp;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH+1:0] shifted;
    logic               finish;
    logic               accept;

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH-1:0]        b_reg;
    logic signed [WIDTH-1:0] rem;
`endif

    assign accept    = start && (state != BUSY);
    assign window    = {lo[1:0], q_m1};
    assign busy      = (state == BUSY);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Booth digit select, partial-product add and weight shift for this cycle.
    always_comb begin
        pp      = '0;
        sum     = '0;
        shifted = '0;
        finish  = 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
        rem     = '0;
`endif
        case (window)
            3'b001, 3'b010: pp = mcand;
            3'b011:         pp = mcand << 1;
            3'b100:         pp = -(mcand << 1);
            3'b101, 3'b110: pp = -mcand;
            default:        pp = '0;
        endcase
        sum     = hi + pp;
        shifted = $signed({sum, lo}) >>> 2;
        finish  = (cnt == LAST);
`ifdef BOOTH_EARLY_TERM_EN
        // Remaining multiplier bits all equal means all remaining digits are 0:
        // apply every outstanding 2-bit weight shift at once and finish.
        rem = $signed(b_reg) >>> (2 * int'(cnt) + 1);
        if ((rem == '0) || (rem == '1)) begin
            shifted = $signed({sum, lo}) >>> (2 * (WIDTH / 2 - int'(cnt)));
            finish  = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is ignored while BUSY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (finish) state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, iterate while BUSY, publish on finish.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            Mulout <= '0;
`ifdef BOOTH_EARLY_TERM_EN
            b_reg  <= '0;
`endif
        end else if (accept) begin
            mcand  <= {{2{A[WIDTH-1]}}, A};
            hi     <= '0;
            lo     <= B;
            q_m1   <= 1'b0;
            cnt    <= '0;
`ifdef BOOTH_EARLY_TERM_EN
            b_reg  <= B;
`endif
        end else if (state == BUSY) begin
            hi     <= shifted[2*WIDTH+1:WIDTH];
            lo     <= shifted[WIDTH-1:0];
            q_m1   <= lo[1];
            cnt    <= cnt + 1'b1;
            if (finish) begin
                Mulout <= shifted[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Testbench for booth_seq_multiplier (WIDTH = 32): directed vector table plus
// hand-written sequences for busy-start, back-to-back and mid-operation reset.
// Latency expectations follow BOOTH_EARLY_TERM_EN when it is defined.
module tb_booth_seq_multiplier;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] Mulout;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int          lat_early;
    } vec_t;

    vec_t vecs[12];

    booth_seq_multiplier #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .Mulout    (Mulout),
        .dbg_state (dbg_state)
    );

    // Clock / reset block.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int lat_early);
`ifdef BOOTH_EARLY_TERM_EN
        return lat_early;
`else
        return (lat_early > 0) ? 16 : 16;
`endif
    endfunction

    // Wait for done after the accepting edge; lat counts edges after it.
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    // Driver: one full multiply with operand scrambling after acceptance.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] prod, output int lat);
        @(negedge clock);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        check("busy_rise", {63'd0, busy}, 64'd1);
        @(negedge clock);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        wait_done(lat);
        prod = Mulout;
        @(posedge clock);
        #1;
        check("done_fall", {63'd0, done}, 64'd0);
        check("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] prod;
        int          lat;
        int          done_cnt;

        vecs[0]  = '{32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 2};
        vecs[1]  = '{32'hFFFF_FFFB, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFF1, 2};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 16};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 16};
        vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 64'h0000_0000_0000_0000, 1};
        vecs[5]  = '{32'h0000_0009, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF7, 1};
        vecs[6]  = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 9};
        vecs[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 16};
        vecs[9]  = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 16};
        vecs[10] = '{32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1};
        vecs[11] = '{32'h0000_1234, 32'h0000_0100, 64'h0000_0000_0012_3400, 5};

        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_mulout", Mulout, 64'd0);
        check("reset_state", {62'd0, dbg_state}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, prod, lat);
            check($sformatf("vec%0d_prod", i), prod, vecs[i].prod);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].lat_early)));
        end

        // Second start and operand change while BUSY are ignored.
        @(negedge clock);
        A = 32'h8000_0000;
        B = 32'h8000_0000;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        A = 32'h0000_0001;
        B = 32'h0000_0001;
        lat = 0;
        while (lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) break;
            if (lat == 3) start = 1'b1;
            if (lat == 4) start = 1'b0;
        end
        check("busy_start_prod", Mulout, 64'h4000_0000_0000_0000);
        check("busy_start_lat", 64'(lat), 64'd16);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        #1;
        check("busy_start_done_fall", {63'd0, done}, 64'd0);

        // Back-to-back: start held high through DONE.
        @(negedge clock);
        A = 32'h8000_0000;
        B = 32'h8000_0000;
        start = 1'b1;
        @(posedge clock);
        #1;
        A = 32'h7FFF_FFFF;
        B = 32'h7FFF_FFFF;
        wait_done(lat);
        check("b2b_first_prod", Mulout, 64'h4000_0000_0000_0000);
        check("b2b_first_lat", 64'(lat), 64'd16);
        @(posedge clock);
        #1;
        check("b2b_done_single", {63'd0, done}, 64'd0);
        check("b2b_second_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        wait_done(lat);
        check("b2b_second_prod", Mulout, 64'h3FFF_FFFF_0000_0001);
        check("b2b_second_lat", 64'(lat), 64'd16);
        @(posedge clock);
        #1;
        check("b2b_second_done_fall", {63'd0, done}, 64'd0);

        // Reset during iteration 5 aborts immediately.
        @(negedge clock);
        A = 32'h8000_0000;
        B = 32'h8000_0000;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_mulout", Mulout, 64'd0);
        check("rst_mid_state", {62'd0, dbg_state}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clock);
            #1;
            if (done || busy) done_cnt++;
        end
        check("rst_no_spurious_done", 64'(done_cnt), 64'd0);

        // Recovery after reset.
        do_op(32'h0000_0007, 32'h0000_0006, prod, lat);
        check("recover_prod", prod, 64'd42);
        check("recover_lat", 64'(lat), 64'(exp_lat(2)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
